// File: rtl/nn_product_accumulator_pkg.sv
// Shared NN datapath constants and helpers, reused by the accumulator and
// later pooling/ReLU stages.
package nn_product_accumulator_pkg;

  localparam int DIN_WIDTH = 10;
  localparam int LEN_MAX   = 16;
  localparam int CNT_WIDTH = 5;
  localparam int ACC_WIDTH = 14;
  localparam int OUT_WIDTH = 12;

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << OUT_WIDTH) - 1);

  // Unsigned saturate from the accumulator width down to the output width.
  function automatic logic [OUT_WIDTH-1:0] sat_u(input logic [ACC_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = '1;
    end else begin
      r = v[OUT_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_out_reg_slice.sv
// Single-entry valid/ready output register. A load and a drain in the same
// cycle keep valid high and take the new data, giving 1 result/cycle.
module nn_out_reg_slice
  import nn_product_accumulator_pkg::*;
#(
  parameter int W = OUT_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         can_load_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Handshake: a beat transfers on a cycle where out_valid_o && out_ready_i.
  // The producer may only assert load_i while can_load_o is high.
  assign can_load_o  = !(valid_q && !out_ready_i);
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/nn_product_accumulator.sv
// Sums groups of 1..LEN_MAX unsigned products and emits one saturated sum
// per group through a single output register.
module nn_product_accumulator
  import nn_product_accumulator_pkg::*;
(
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic [DIN_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] len_d;

  logic [CNT_WIDTH-1:0] len_clamped;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [ACC_WIDTH-1:0] sum;
  logic                 accept;
  logic                 last_beat;
  logic                 load;
  logic                 can_load;

  assign in_ready = can_load;
  assign accept   = in_valid && in_ready && !clr;
  assign busy     = (cnt_q != '0);

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = CNT_WIDTH'(1);
    end else if (cfg_len > CNT_WIDTH'(LEN_MAX)) begin
      len_clamped = CNT_WIDTH'(LEN_MAX);
    end
  end

  // The first beat of a group uses the freshly clamped length; later beats
  // use the captured one so mid-group cfg_len changes are ignored.
  assign len_eff   = (cnt_q == '0) ? len_clamped : len_q;
  assign last_beat = (cnt_q == (len_eff - CNT_WIDTH'(1)));
  assign sum       = acc_q + ACC_WIDTH'(in_data);
  assign load      = accept && last_beat;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == '0) begin
        len_d = len_clamped;
      end
      if (last_beat) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= CNT_WIDTH'(1);
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  nn_out_reg_slice #(
    .W (OUT_WIDTH)
  ) u_out_reg (
    .clk_i       (ap_clk),
    .rst_n_i     (ap_rst_n),
    .load_i      (load),
    .load_data_i (sat_u(sum)),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .can_load_o  (can_load)
  );

endmodule

// File: tb/tb_nn_product_accumulator.sv
// Bench for nn_product_accumulator: directed scenarios with literal results
// plus randomized traffic, all checked against a group-level model.
module tb_nn_product_accumulator;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        clr;
  logic [4:0]  cfg_len;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  nn_product_accumulator dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .clr       (clr),
    .cfg_len   (cfg_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // ---------------- model ----------------
  int        m_grp[$];
  int        m_len;
  int        m_valid;
  int        m_data;
  bit        model_ok = 1'b0;
  bit        last_acc;
  logic [11:0] drained_q[$];
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input int c);
    if (c == 0) return 1;
    if (c > 16) return 16;
    return c;
  endfunction

  // Advance the model over the upcoming rising edge using current inputs.
  task automatic model_step();
    int total;
    bit ready;
    bit new_out;
    last_acc = 1'b0;
    if (!ap_rst_n) begin
      m_grp.delete();
      m_valid  = 0;
      m_data   = 0;
      model_ok = 1'b1;
      return;
    end
    ready   = !(m_valid != 0 && !out_ready);
    new_out = 1'b0;
    if (clr) begin
      m_grp.delete();
    end else if (in_valid && ready) begin
      last_acc = 1'b1;
      if (m_grp.size() == 0) m_len = clamp_len(int'(cfg_len));
      m_grp.push_back(int'(in_data));
      if (m_grp.size() == m_len) begin
        total = 0;
        foreach (m_grp[i]) total += m_grp[i];
        m_data  = (total > 4095) ? 4095 : total;
        new_out = 1'b1;
        m_grp.delete();
      end
    end
    if (new_out) m_valid = 1;
    else if (m_valid != 0 && out_ready) m_valid = 0;
  endtask

  // One clock: compare DUT to model at the falling edge, then step.
  task automatic cyc();
    @(negedge ap_clk);
    if (model_ok) begin
      chk("out_valid", int'(out_valid), m_valid);
      chk("out_data", int'(out_data), m_data);
      chk("busy", int'(busy), int'(m_grp.size() != 0));
      chk("in_ready", int'(in_ready), int'(!(m_valid != 0 && !out_ready)));
      if (out_valid && out_ready && ap_rst_n) drained_q.push_back(out_data);
    end
    model_step();
    @(posedge ap_clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int d);
    int n;
    in_valid = 1'b1;
    in_data  = 10'(d);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) chk("send_timeout", n, -1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic check_drained(input string name);
    chk({name, "_count"}, drained_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < drained_q.size()) chk(name, int'(drained_q[i]), int'(exp_q[i]));
    end
    drained_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ap_rst_n  = 1'b0;
    clr       = 1'b0;
    cfg_len   = 5'd1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) cyc();
    ap_rst_n = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    drained_q.delete();

    // 3x3 window of 100s
    cfg_len = 5'd9;
    repeat (9) send(100);
    chk("win9_valid", int'(out_valid), 1);
    chk("win9_data", int'(out_data), 900);
    chk("win9_busy", int'(busy), 0);
    idle(2);
    exp_q.push_back(12'd900);
    check_drained("win9");

    // Saturation: 16 * 1023 = 16368 -> 4095
    cfg_len = 5'd16;
    repeat (16) send(1023);
    chk("sat_data", int'(out_data), 4095);
    idle(2);
    exp_q.push_back(12'd4095);
    check_drained("sat");

    // Stall, then drain and accept in the same cycle
    cfg_len   = 5'd3;
    out_ready = 1'b0;
    send(5); send(6); send(7);
    in_valid = 1'b1;
    in_data  = 10'd1;
    repeat (3) cyc();
    chk("stall_data", int'(out_data), 18);
    chk("stall_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    cyc();
    chk("stall_release_busy", int'(busy), 1);
    send(2); send(3);
    chk("stall_next_data", int'(out_data), 6);
    idle(2);
    exp_q.push_back(12'd18);
    exp_q.push_back(12'd6);
    check_drained("stall");

    // Length-1 groups back-to-back: output stays valid, no bubble
    cfg_len = 5'd0;
    send(7); send(8); send(9);
    chk("len1_valid", int'(out_valid), 1);
    chk("len1_data", int'(out_data), 9);
    idle(2);
    exp_q.push_back(12'd7);
    exp_q.push_back(12'd8);
    exp_q.push_back(12'd9);
    check_drained("len1");

    // clr aborts the partial group and drops the beat presented with it
    cfg_len = 5'd4;
    send(50); send(50);
    clr = 1'b1; in_valid = 1'b1; in_data = 10'd99;
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_busy", int'(busy), 0);
    repeat (4) send(10);
    idle(2);
    exp_q.push_back(12'd40);
    check_drained("clr");

    // cfg_len above LEN_MAX clamps to 16
    cfg_len = 5'd20;
    repeat (15) send(1);
    chk("clamp_busy", int'(busy), 1);
    chk("clamp_early_valid", int'(out_valid), 0);
    send(1);
    chk("clamp_data", int'(out_data), 16);
    idle(2);
    exp_q.push_back(12'd16);
    check_drained("clamp");

    // cfg_len change mid-group is ignored
    cfg_len = 5'd4;
    send(5);
    cfg_len = 5'd2;
    send(5);
    chk("midcfg_no_early", int'(out_valid), 0);
    send(5); send(5);
    chk("midcfg_data", int'(out_data), 20);
    idle(2);
    exp_q.push_back(12'd20);
    check_drained("midcfg");

    // Reset with a stalled result, then reset mid-group
    out_ready = 1'b0;
    cfg_len   = 5'd1;
    send(9);
    ap_rst_n = 1'b0;
    cyc();
    ap_rst_n = 1'b1;
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_out_data", int'(out_data), 0);
    chk("rst2_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    cfg_len   = 5'd3;
    send(1); send(1);
    ap_rst_n = 1'b0;
    cyc();
    ap_rst_n = 1'b1;
    chk("rst3_busy", int'(busy), 0);
    cfg_len = 5'd2;
    send(3); send(4);
    idle(2);
    exp_q.push_back(12'd7);
    check_drained("rst_fresh");

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      ap_rst_n  = ($urandom_range(0, 149) != 0);
      clr       = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
      cfg_len   = 5'($urandom_range(0, 20));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    ap_rst_n = 1'b1;
    clr      = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
